// File: rtl/spi_pkg.sv
// Shared SPI command definitions: opcodes, address-tracker states, command word layout.
package spi_pkg;

  localparam int unsigned CMD_W  = 10;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } opcode_e;

  typedef enum logic {
    NO_ADDR = 1'b0,
    ADDR_OK = 1'b1
  } trk_state_e;

  typedef struct packed {
    opcode_e             op;
    logic [DATA_W-1:0]   payload;
  } cmd_t;

endpackage

// File: rtl/spi_ram_if.sv
// Command/response link between the SPI slave (master side) and the RAM (slave side).
//   din      : 10-bit command word {opcode, payload}
//   rx_valid : single-cycle strobe qualifying din
//   dout     : read data back to the SPI slave
//   tx_valid : qualifies dout
//   err      : one-cycle pulse on an illegal command sequence
interface spi_ram_if;
  import spi_pkg::*;

  logic [CMD_W-1:0]  din;
  logic              rx_valid;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              err;

  modport master (output din, output rx_valid, input dout, input tx_valid, input err);
  modport slave  (input din, input rx_valid, output dout, output tx_valid, output err);
endinterface

// File: rtl/spi_ram_array.sv
// Single-port byte storage: one write port, one registered read port, shared address.
//   clk, rst : clock and synchronous reset (clears only the read register)
//   we, re   : write / read enables (mutually exclusive by construction in the caller)
//   addr     : shared access address
//   wdata    : write data
//   rdata    : registered read data, holds until the next read or reset
module spi_ram_array
  import spi_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Storage is never reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read register doubles as the output data register.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/spi_ram.sv
// Command-driven RAM behind an SPI slave: decodes address/data commands, tracks
// whether write and read addresses have been loaded, and returns read data.
//   clk, rst : clock and synchronous active-high reset
//   bus      : spi_ram_if slave modport (din, rx_valid in; dout, tx_valid, err out)
module spi_ram
  import spi_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8,
  parameter bit          AUTO_INC  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  spi_ram_if.slave   bus
);

  cmd_t                 cmd;
  trk_state_e           wr_state, wr_state_nxt;
  trk_state_e           rd_state, rd_state_nxt;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic                 wr_ok_c, wr_bad_c, rd_ok_c, rd_bad_c;
  logic                 mem_we_c, mem_re_c;
  logic [ADDR_SIZE-1:0] mem_addr_c;
  logic                 tx_valid, err;
  logic [DATA_W-1:0]    rdata;

  assign cmd = cmd_t'(bus.din);

  // Tracker state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= NO_ADDR;
      rd_state <= NO_ADDR;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
    end
  end

  // Tracker next-state and command legality decode.
  always_comb begin
    wr_state_nxt = wr_state;
    rd_state_nxt = rd_state;
    wr_ok_c      = 1'b0;
    wr_bad_c     = 1'b0;
    rd_ok_c      = 1'b0;
    rd_bad_c     = 1'b0;
    if (bus.rx_valid) begin
      unique case (cmd.op)
        WR_ADDR: wr_state_nxt = ADDR_OK;
        RD_ADDR: rd_state_nxt = ADDR_OK;
        WR_DATA: begin
          wr_ok_c  = (wr_state == ADDR_OK);
          wr_bad_c = (wr_state == NO_ADDR);
        end
        RD_DATA: begin
          rd_ok_c  = (rd_state == ADDR_OK);
          rd_bad_c = (rd_state == NO_ADDR);
        end
        default: ;
      endcase
    end
  end

  // Reset discards any coincident command, so it also blocks the memory access.
  assign mem_we_c   = wr_ok_c & ~rst;
  assign mem_re_c   = rd_ok_c & ~rst;
  assign mem_addr_c = mem_we_c ? wr_addr : rd_addr;

  // Independent write/read address registers with optional post-increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr <= '0;
      rd_addr <= '0;
    end else if (bus.rx_valid) begin
      if (cmd.op == WR_ADDR)      wr_addr <= ADDR_SIZE'(cmd.payload);
      else if (wr_ok_c && AUTO_INC) wr_addr <= wr_addr + ADDR_SIZE'(1);
      if (cmd.op == RD_ADDR)      rd_addr <= ADDR_SIZE'(cmd.payload);
      else if (rd_ok_c && AUTO_INC) rd_addr <= rd_addr + ADDR_SIZE'(1);
    end
  end

  // tx_valid holds until the next strobe; err is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid <= 1'b0;
      err      <= 1'b0;
    end else if (bus.rx_valid) begin
      tx_valid <= rd_ok_c;
      err      <= wr_bad_c | rd_bad_c;
    end else begin
      err      <= 1'b0;
    end
  end

  spi_ram_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we_c),
    .re    (mem_re_c),
    .addr  (mem_addr_c),
    .wdata (cmd.payload),
    .rdata (rdata)
  );

  assign bus.dout     = rdata;
  assign bus.tx_valid = tx_valid;
  assign bus.err      = err;

endmodule

// File: tb/tb_spi_ram.sv
// Scoreboard bench for spi_ram: one instance with AUTO_INC=0, one with AUTO_INC=1.
module tb_spi_ram;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  spi_ram_if bus0 ();
  spi_ram_if bus1 ();

  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b0)) dut0 (
    .clk (clk), .rst (rst0), .bus (bus0.slave));
  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b1)) dut1 (
    .clk (clk), .rst (rst1), .bus (bus1.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    int         sel;
    logic [7:0] d;
    logic       v;
    logic       e;
    string      name;
  } exp_t;

  exp_t sb[$];

  // Drive one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic step(input int sel, input logic r, input logic rv, input logic [1:0] op,
                      input logic [7:0] pl, input logic [7:0] ed, input logic ev,
                      input logic ee, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;
    bus0.rx_valid = 1'b0; bus1.rx_valid = 1'b0;
    bus0.din = 10'h3FF; bus1.din = 10'h3FF;
    if (sel == 0) begin
      rst0 = r; bus0.rx_valid = rv;
      if (rv) bus0.din = {op, pl};
    end else begin
      rst1 = r; bus1.rx_valid = rv;
      if (rv) bus1.din = {op, pl};
    end
    x.due = cyc + 1; x.sel = sel; x.d = ed; x.v = ev; x.e = ee; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic cmd(input int sel, input logic [1:0] op, input logic [7:0] pl,
                     input logic [7:0] ed, input logic ev, input logic ee, input string nm);
    step(sel, 1'b0, 1'b1, op, pl, ed, ev, ee, nm);
  endtask

  task automatic idle(input int sel, input logic [7:0] ed, input logic ev, input string nm);
    step(sel, 1'b0, 1'b0, 2'b00, 8'h00, ed, ev, 1'b0, nm);
  endtask

  task automatic reset(input int sel, input logic rv, input logic [1:0] op,
                       input logic [7:0] pl, input string nm);
    step(sel, 1'b1, rv, op, pl, 8'h00, 1'b0, 1'b0, nm);
  endtask

  // Monitor: compare DUT outputs against the queued expectation for this cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] ad;
    logic av, ae;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      ad = (e.sel == 0) ? bus0.dout : bus1.dout;
      av = (e.sel == 0) ? bus0.tx_valid : bus1.tx_valid;
      ae = (e.sel == 0) ? bus0.err : bus1.err;
      checks = checks + 1;
      if (e.due != cyc || ad !== e.d || av !== e.v || ae !== e.e) begin
        errors = errors + 1;
        $display("FAIL %s dut%0d: got dout=%h tx_valid=%b err=%b, want dout=%h tx_valid=%b err=%b (due %0d at %0d)",
                 e.name, e.sel, ad, av, ae, e.d, e.v, e.e, e.due, cyc);
      end
    end
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    bus0.rx_valid = 1'b0; bus1.rx_valid = 1'b0;
    bus0.din = '0; bus1.din = '0;

    // ---- dut0, AUTO_INC = 0 ----
    reset(0, 1'b0, 2'b00, 8'h00, "reset_state");
    cmd(0, RD_DATA, 8'h00, 8'h00, 1'b0, 1'b1, "rd_no_addr_err");
    idle(0, 8'h00, 1'b0, "err_one_cycle");
    cmd(0, WR_ADDR, 8'h00, 8'h00, 1'b0, 1'b0, "wr_addr_00");
    cmd(0, WR_DATA, 8'h5A, 8'h00, 1'b0, 1'b0, "wr_data_5a");
    reset(0, 1'b0, 2'b00, 8'h00, "reset_again");
    cmd(0, WR_DATA, 8'h77, 8'h00, 1'b0, 1'b1, "wr_no_addr_err");
    idle(0, 8'h00, 1'b0, "err_clear");
    cmd(0, RD_ADDR, 8'h00, 8'h00, 1'b0, 1'b0, "rd_addr_00");
    cmd(0, RD_DATA, 8'h00, 8'h5A, 1'b1, 1'b0, "loc00_unchanged");
    cmd(0, WR_ADDR, 8'h3A, 8'h5A, 1'b0, 1'b0, "wr_addr_3a");
    cmd(0, WR_DATA, 8'hC5, 8'h5A, 1'b0, 1'b0, "wr_data_c5");
    cmd(0, RD_ADDR, 8'h3A, 8'h5A, 1'b0, 1'b0, "rd_addr_3a");
    cmd(0, RD_DATA, 8'h00, 8'hC5, 1'b1, 1'b0, "rd_data_c5");
    for (int i = 0; i < 9; i++) idle(0, 8'hC5, 1'b1, "tx_hold");
    cmd(0, WR_ADDR, 8'h10, 8'hC5, 1'b0, 1'b0, "tx_clear_on_strobe");
    cmd(0, WR_DATA, 8'h99, 8'hC5, 1'b0, 1'b0, "wr_data_99");
    cmd(0, RD_ADDR, 8'h10, 8'hC5, 1'b0, 1'b0, "rd_addr_10");
    cmd(0, RD_DATA, 8'h00, 8'h99, 1'b1, 1'b0, "rd_10_first");
    cmd(0, RD_DATA, 8'h00, 8'h99, 1'b1, 1'b0, "rd_10_persist");
    cmd(0, WR_ADDR, 8'h10, 8'h99, 1'b0, 1'b0, "wr_addr_10");
    reset(0, 1'b1, WR_DATA, 8'hEE, "rst_beats_wr_data");
    cmd(0, WR_DATA, 8'h55, 8'h00, 1'b0, 1'b1, "wr_tracker_reset");
    cmd(0, RD_ADDR, 8'h10, 8'h00, 1'b0, 1'b0, "rd_addr_10b");
    cmd(0, RD_DATA, 8'h00, 8'h99, 1'b1, 1'b0, "mem10_unchanged");
    reset(0, 1'b0, 2'b00, 8'h00, "rst_clears_tx");
    cmd(0, RD_DATA, 8'h00, 8'h00, 1'b0, 1'b1, "rd_tracker_reset");
    cmd(0, WR_ADDR, 8'h05, 8'h00, 1'b0, 1'b0, "wr_addr_05");
    cmd(0, WR_DATA, 8'hA7, 8'h00, 1'b0, 1'b0, "wr_data_a7");
    cmd(0, RD_ADDR, 8'h05, 8'h00, 1'b0, 1'b0, "rd_addr_05");
    cmd(0, RD_DATA, 8'h00, 8'hA7, 1'b1, 1'b0, "rd_data_a7");

    // ---- dut1, AUTO_INC = 1 ----
    reset(1, 1'b0, 2'b00, 8'h00, "inc_reset_state");
    cmd(1, WR_ADDR, 8'hFF, 8'h00, 1'b0, 1'b0, "inc_wr_addr_ff");
    cmd(1, WR_DATA, 8'h11, 8'h00, 1'b0, 1'b0, "inc_wr_11");
    cmd(1, WR_DATA, 8'h22, 8'h00, 1'b0, 1'b0, "inc_wr_22_wrap");
    cmd(1, RD_ADDR, 8'hFF, 8'h00, 1'b0, 1'b0, "inc_rd_addr_ff");
    cmd(1, RD_DATA, 8'h00, 8'h11, 1'b1, 1'b0, "inc_rd_ff");
    cmd(1, RD_DATA, 8'h00, 8'h22, 1'b1, 1'b0, "inc_rd_00_wrap");
    cmd(1, WR_DATA, 8'h33, 8'h22, 1'b0, 1'b0, "inc_wr_33_at_01");
    cmd(1, RD_ADDR, 8'h01, 8'h22, 1'b0, 1'b0, "inc_rd_addr_01");
    cmd(1, RD_DATA, 8'h00, 8'h33, 1'b1, 1'b0, "inc_rd_01");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations never compared, want 0", sb.size());
      errors = errors + sb.size();
      checks = checks + sb.size();
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_ram.md
SPI_RAM -- requirements
Module: spi_ram

Interface
REQ-001 Parameter MEM_DEPTH, default 256, number of 8-bit words.
REQ-002 Parameter ADDR_SIZE, default 8, address width; MEM_DEPTH SHALL equal 2**ADDR_SIZE.
REQ-003 Parameter AUTO_INC, default 0, when 1 the address register SHALL post-increment after each data access.
REQ-004 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 din  input  10  command word from the SPI slave; din[9:8] opcode, din[7:0] payload.
REQ-007 rx_valid  input  1  single-cycle strobe qualifying din.
REQ-008 dout  output  8  read data to the SPI slave (tx_data).
REQ-009 tx_valid  output  1  qualifies dout.
REQ-010 err  output  1  single-cycle pulse flagging an illegal command sequence.

Function
REQ-011 din SHALL be ignored on any cycle where rx_valid=0.
REQ-012 Opcode 2'b00 (WR_ADDR) SHALL load wr_addr <= din[7:0] and set wr_addr_ok.
REQ-013 Opcode 2'b01 (WR_DATA) with wr_addr_ok=1 SHALL write mem[wr_addr] <= din[7:0] at that edge.
REQ-014 Opcode 2'b10 (RD_ADDR) SHALL load rd_addr <= din[7:0] and set rd_addr_ok.
REQ-015 Opcode 2'b11 (RD_DATA) with rd_addr_ok=1 SHALL register dout <= mem[rd_addr] and tx_valid <= 1 on the same edge: one-cycle latency from rx_valid.
REQ-016 Once set, tx_valid SHALL remain 1 and dout stable until the next rx_valid edge, where tx_valid SHALL clear unless that command is another legal RD_DATA (then dout and tx_valid are reloaded).
REQ-017 WR_DATA with wr_addr_ok=0 SHALL not write memory and SHALL pulse err for exactly one cycle.
REQ-018 RD_DATA with rd_addr_ok=0 SHALL not assert tx_valid, SHALL leave dout unchanged, and SHALL pulse err for one cycle.
REQ-019 Sequence tracker states: NO_ADDR, ADDR_OK, kept independently for write and read paths; transition NO_ADDR->ADDR_OK on the matching address opcode only; reset returns to NO_ADDR.
REQ-020 AUTO_INC=0: addresses SHALL persist, allowing repeated WR_DATA/RD_DATA to the same location.
REQ-021 AUTO_INC=1: wr_addr SHALL increment after each legal WR_DATA and rd_addr after each legal RD_DATA, modulo MEM_DEPTH (0xFF -> 0x00 wrap).
REQ-022 Write and read address registers SHALL be independent; WR_ADDR SHALL not affect rd_addr and vice versa.
REQ-023 Memory contents SHALL be undefined after power-up and SHALL NOT be cleared by rst.
REQ-024 Only one memory access SHALL occur per cycle (single port); no access SHALL occur without rx_valid.

Reset
REQ-025 rst=1 at a rising edge SHALL force dout=8'h00, tx_valid=0, err=0, wr_addr=0, rd_addr=0, both trackers to NO_ADDR.
REQ-026 rst SHALL take priority over a coincident rx_valid; that command SHALL be discarded.
REQ-027 Reset asserted while tx_valid=1 SHALL clear tx_valid on that edge.

Structure
REQ-028 Opcode constants WR_ADDR, WR_DATA, RD_ADDR, RD_DATA and tracker state encodings SHALL live in shared package spi_pkg, also used by the SPI slave bench.
REQ-029 The storage array SHALL be a sub-module spi_ram_array (one write port, one registered read port, shared address mux) instantiated once; command decode, trackers and output registers SHALL stay in spi_ram.

Verification
REQ-030 Reset, then WR_ADDR 0x3A, WR_DATA 0xC5, RD_ADDR 0x3A, RD_DATA -> one cycle after the RD_DATA strobe dout=0xC5, tx_valid=1, err never asserted.
REQ-031 After reset, RD_DATA with no RD_ADDR -> err pulses one cycle, tx_valid stays 0, dout stays 0x00; WR_DATA with no WR_ADDR -> err pulse, location 0x00 unchanged on later read.
REQ-032 tx_valid hold: legal RD_DATA then 9 idle cycles -> tx_valid=1 and dout constant all 9 cycles; next WR_ADDR strobe -> tx_valid=0 the following cycle.
REQ-033 AUTO_INC=1: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22; RD_ADDR 0xFF, RD_DATA, RD_DATA -> dout 0x11 then 0x22 (address 0x00).
REQ-034 rst asserted on the same cycle as a WR_DATA strobe to addr 0x10 after WR_ADDR 0x10 -> mem[0x10] unchanged, tracker NO_ADDR, subsequent WR_DATA pulses err.
REQ-035 End-to-end with the SPI slave: SPI read-data frame after read-address 0x05 holding 0xA7 -> MISO shifts 1,0,1,0,0,1,1,1 MSB first.
